// File: rtl/cla16_pipe_if.sv
// cla16_pipe_if: operand/result handshake bundle for the pipelined adder
interface cla16_pipe_if;
   logic        in_valid, in_ready, sub, cin;
   logic        out_valid, out_ready, cout, ovf;
   logic [15:0] a, b, sum;
   modport master (output in_valid, a, b, sub, cin, out_ready,
                   input  in_ready, out_valid, sum, cout, ovf);
   modport slave  (input  in_valid, a, b, sub, cin, out_ready,
                   output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/cla16_pipe.sv
// cla16_pipe: two-stage 16-bit carry-lookahead add/subtract with valid/ready flow control
module cla16_pipe #(
   parameter bit SAT = 1'b0
) (
   input  logic         clk,
   input  logic         reset_n,
   cla16_pipe_if.slave  bus
);
   logic [15:0] g_b_q, g_b_d, p_q, p_d, sum_q, sum_d;
   logic [15:0] bx, g, c, raw;
   logic        c0_q, c0_d, a15_q, a15_d, s1_valid_q, s1_valid_d;
   logic        cout_q, cout_d, ovf_q, ovf_d, out_valid_q, out_valid_d;
   logic        s1_load, s2_load, in_ready, ovf;
   logic [3:0]  gg, pg, cg, ci, t;

   // Flattened 4-bit lookahead: returns carries into positions 1..4 of the group.
   function automatic logic [3:0] cla4(input logic [3:0] gv, pv, input logic cv);
      logic [3:0] r;
      r[0] = gv[0] | (pv[0] & cv);
      r[1] = gv[1] | (pv[1] & gv[0]) | (pv[1] & pv[0] & cv);
      r[2] = gv[2] | (pv[2] & gv[1]) | (pv[2] & pv[1] & gv[0]) | (pv[2] & pv[1] & pv[0] & cv);
      r[3] = gv[3] | (pv[3] & gv[2]) | (pv[3] & pv[2] & gv[1]) | (pv[3] & pv[2] & pv[1] & gv[0])
           | (&pv & cv);
      return r;
   endfunction

   // Handshake: stage 2 frees when empty or drained; stage 1 refills behind it with no bubble.
   always_comb begin
      s2_load     = s1_valid_q & (~out_valid_q | bus.out_ready);
      in_ready    = ~s1_valid_q | s2_load;
      s1_load     = bus.in_valid & in_ready;
      s1_valid_d  = s1_load | (s1_valid_q & ~s2_load);
      out_valid_d = s2_load | (out_valid_q & ~bus.out_ready);
   end

   // Stage 1: invert B for subtraction and capture per-bit generate (active-low) and propagate.
   always_comb begin
      bx    = bus.sub ? ~bus.b : bus.b;
      g_b_d = s1_load ? ~(bus.a & bx) : g_b_q;
      p_d   = s1_load ? (bus.a ^ bx) : p_q;
      c0_d  = s1_load ? (bus.sub | bus.cin) : c0_q;
      a15_d = s1_load ? bus.a[15] : a15_q;
   end

   // Stage 2: group lookahead, second-level lookahead across groups, then sum and saturation.
   always_comb begin
      g = ~g_b_q;
      c = '0;
      t = '0;
      for (int k = 0; k < 4; k++) begin
         t     = cla4(g[4*k +: 4], p_q[4*k +: 4], 1'b0);
         gg[k] = t[3];
         pg[k] = &p_q[4*k +: 4];
      end
      cg = cla4(gg, pg, c0_q);
      ci = {cg[2:0], c0_q};
      for (int k = 0; k < 4; k++) begin
         t              = cla4(g[4*k +: 4], p_q[4*k +: 4], ci[k]);
         c[4*k]         = ci[k];
         c[4*k+1 +: 3]  = t[2:0];
      end
      raw    = p_q ^ c;
      ovf    = c[15] ^ cg[3];
      sum_d  = s2_load ? ((SAT && ovf) ? (a15_q ? 16'h8000 : 16'h7fff) : raw) : sum_q;
      cout_d = s2_load ? cg[3] : cout_q;
      ovf_d  = s2_load ? ovf : ovf_q;
   end

   // Pipeline registers; reset discards every in-flight beat.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         g_b_q       <= '0;
         p_q         <= '0;
         c0_q        <= 1'b0;
         a15_q       <= 1'b0;
         s1_valid_q  <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         g_b_q       <= g_b_d;
         p_q         <= p_d;
         c0_q        <= c0_d;
         a15_q       <= a15_d;
         s1_valid_q  <= s1_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla16_pipe.sv
// tb_cla16_pipe: random and directed checks of both saturation variants against a queue model
module tb_cla16_pipe;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic        in_valid = 1'b0, sub = 1'b0, cin = 1'b0, out_ready = 1'b1;
   logic [15:0] a = '0, b = '0;
   int          nchk = 0, nfail = 0, cyc = 0, n_acc = 0, n_out = 0;

   typedef struct {
      logic [15:0] s0, s1;
      logic        c, o;
      int          t;
   } beat_t;
   beat_t q[$];
   logic  mv, mir;

   cla16_pipe_if if0 ();
   cla16_pipe_if if1 ();
   assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
   assign if0.a = a;                assign if1.a = a;
   assign if0.b = b;                assign if1.b = b;
   assign if0.sub = sub;            assign if1.sub = sub;
   assign if0.cin = cin;            assign if1.cin = cin;
   assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

   cla16_pipe #(.SAT(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
   cla16_pipe #(.SAT(1'b1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s got=%h exp=%h", n, act, exp);
      end
   endtask

   // Reference: plain 17-bit addition, overflow from operand and result sign bits.
   function automatic beat_t model(input logic [15:0] ta, tbv, input logic ts, tc, input int tt);
      beat_t       m;
      logic [15:0] bv;
      logic [16:0] full;
      bv   = ts ? ~tbv : tbv;
      full = {1'b0, ta} + {1'b0, bv} + {16'd0, ts | tc};
      m.o  = (ta[15] == bv[15]) && (full[15] != ta[15]);
      m.c  = full[16];
      m.s0 = full[15:0];
      m.s1 = m.o ? (ta[15] ? 16'h8000 : 16'h7fff) : full[15:0];
      m.t  = tt;
      return m;
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         n_acc -= q.size();
         q.delete();
      end else begin
         mv  = q.size() != 0 && q[0].t + 2 <= cyc;
         mir = !(q.size() >= 2 && !out_ready);
         chk("out_valid0", 32'(if0.out_valid), 32'(mv));
         chk("out_valid1", 32'(if1.out_valid), 32'(mv));
         chk("in_ready0", 32'(if0.in_ready), 32'(mir));
         chk("in_ready1", 32'(if1.in_ready), 32'(mir));
         if (mv) begin
            chk("sum0", 32'(if0.sum), 32'(q[0].s0));
            chk("sum1", 32'(if1.sum), 32'(q[0].s1));
            chk("cout0", 32'(if0.cout), 32'(q[0].c));
            chk("cout1", 32'(if1.cout), 32'(q[0].c));
            chk("ovf0", 32'(if0.ovf), 32'(q[0].o));
            chk("ovf1", 32'(if1.ovf), 32'(q[0].o));
         end
         if (mv && out_ready) begin
            void'(q.pop_front());
            n_out++;
         end
         if (in_valid && mir) begin
            q.push_back(model(a, b, sub, cin, cyc));
            n_acc++;
         end
      end
      cyc++;
   end

   task automatic beat(input logic [15:0] ta, tbv, input logic ts, tc,
                       input logic [15:0] e0, e1, input logic ec, eo);
      @(posedge clk); #1;
      a = ta; b = tbv; sub = ts; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("lat_early", 32'(if0.out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_valid", 32'(if0.out_valid), 32'd1);
      chk("d_sum0", 32'(if0.sum), 32'(e0));
      chk("d_sum1", 32'(if1.sum), 32'(e1));
      chk("d_cout0", 32'(if0.cout), 32'(ec));
      chk("d_cout1", 32'(if1.cout), 32'(ec));
      chk("d_ovf0", 32'(if0.ovf), 32'(eo));
      chk("d_ovf1", 32'(if1.ovf), 32'(eo));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int w;
      reset_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h0001;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1; in_valid = 1'b0;
      chk("rst_valid0", 32'(if0.out_valid), 32'd0);
      chk("rst_valid1", 32'(if1.out_valid), 32'd0);
      chk("rst_sum0", 32'(if0.sum), 32'd0);
      chk("rst_sum1", 32'(if1.sum), 32'd0);
      chk("rst_cout", 32'(if0.cout), 32'd0);
      chk("rst_ovf", 32'(if0.ovf), 32'd0);
      chk("rst_in_ready", 32'(if0.in_ready), 32'd1);
      repeat (3) @(posedge clk);
      beat(16'hffff, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      beat(16'h7fff, 16'h0000, 1'b0, 1'b1, 16'h8000, 16'h7fff, 1'b0, 1'b1);
      beat(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hfffe, 16'hfffe, 1'b0, 1'b0);
      beat(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7fff, 16'h8000, 1'b1, 1'b1);
      beat(16'h7fff, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7fff, 1'b0, 1'b1);
      beat(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 16'h0007, 1'b0, 1'b0);
      @(posedge clk); #1;
      fork
         begin
            for (int i = 1; i <= 4; i++) begin
               a = 16'(i); b = 16'h0010; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
               for (int k = 0; k < 20; k++) begin
                  @(negedge clk);
                  if (if0.in_ready) break;
                  @(posedge clk); #1;
               end
               @(posedge clk); #1;
            end
            in_valid = 1'b0;
         end
         begin
            w = 0;
            while (!if0.out_valid && w < 20) begin
               @(posedge clk); #1;
               w++;
            end
            chk("bp_seen", 32'(if0.out_valid), 32'd1);
            out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("bp_hold", 32'(if0.sum), 32'h0011);
               chk("bp_in_ready", 32'(if0.in_ready), 32'd0);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
            for (int j = 0; j < 4; j++) begin
               @(negedge clk);
               chk("bp_valid", 32'(if0.out_valid), 32'd1);
               chk("bp_order", 32'(if0.sum), 32'h0011 + 32'(j));
               @(posedge clk); #1;
            end
         end
      join
      for (int i = 0; i < 10000; i++) begin
         @(posedge clk); #1;
         reset_n   = !(i >= 5000 && i < 5002);
         in_valid  = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         a         = ($urandom_range(0, 7) == 0) ? 16'h7fff : 16'($urandom);
         b         = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
         sub       = 1'($urandom);
         cin       = 1'($urandom);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("drain_empty", 32'(q.size()), 32'd0);
      chk("beat_count", 32'(n_out), 32'(n_acc));
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule

// File: doc/cla16_pipe.md
# cla16_pipe

Two-stage pipelined 16-bit add/subtract unit with valid/ready handshakes on both sides. Stage 1 conditions the operands and registers per-bit active-low generate and propagate vectors. Stage 2 resolves carries with four 4-bit lookahead groups plus a second-level group lookahead, then forms the sum, carry-out, signed overflow and optional saturation. It sits between the operand-select logic and the result writeback/accumulator stage of the datapath.

## Interface
- SAT, 0, 1 = clamp signed overflow to 0x7FFF / 0x8000; 0 = wrap.
- clk  in  1  rising-edge clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  stage 1 can accept a beat (combinational).
- a  in  16  operand A.
- b  in  16  operand B.
- sub  in  1  1 = A − B (cin ignored); 0 = A + B + cin.
- cin  in  1  carry-in, used only when sub=0.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- sum  out  16  result (saturated if SAT=1 and ovf=1).
- cout  out  1  carry out of bit 15 (raw, never saturated).
- ovf  out  1  signed two's-complement overflow.

## Operation
- Operand conditioning: bx = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage 1 registers: g_b[i] = ~(a[i] & bx[i]); p[i] = a[i] ^ bx[i]; c0; a[15]; s1_valid.
- Stage 2, combinational from the stage-1 registers:
  - Group k (bits 4k..4k+3) produces internal carries, a group generate G_k and a group propagate P_k = &p[4k+3:4k].
  - Second level: C4 = G0 | P0·c0; C8 = G1 | P1·C4; C12 = G2 | P2·C8; C16 = G3 | P3·C12, flattened as a lookahead, not rippled.
  - raw[i] = p[i] ^ c[i]; cout = C16; ovf = c15 ^ C16.
  - SAT=1 and ovf=1 forces sum = a[15] ? 0x8000 : 0x7FFF. Otherwise sum = raw.
- Stage 2 registers: sum, cout, ovf, out_valid.
- Flow control:
  - s2_load = s1_valid & (~out_valid | out_ready).
  - s1_load = in_valid & in_ready.
  - in_ready = ~s1_valid | s2_load.
- Stage 1 captures on s1_load. s1_valid next = s1_load | (s1_valid & ~s2_load).
- out_valid next = s2_load | (out_valid & ~out_ready).
- Beats are never dropped, duplicated or reordered. At most 2 beats are in flight.

## Timing
- Reset (reset_n=0 at a clk edge): s1_valid=0, out_valid=0, sum=0x0000, cout=0, ovf=0, and all stage-1 data registers=0. in_ready=1 in the first cycle after release.
- Reset asserted mid-operation discards all in-flight beats; no result is emitted for them. in_valid is ignored while reset_n=0.
- Latency: a beat accepted at edge N (in_valid & in_ready) shows out_valid=1 with its result after edge N+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure: while out_valid & ~out_ready, sum, cout and ovf hold stable. Stage 1 keeps one further beat; in_ready falls once both stages are full.
- Simultaneous events:
  - out_ready and a new s2_load in the same cycle: the old result is consumed and the new one loaded; out_valid stays 1.
  - s2_load and s1_load in the same cycle: stage 1 is replaced, with no bubble.
- No combinational path from a/b to sum. in_ready depends only on s1_valid, out_valid and out_ready.

## Test plan
- Reset: reset_n=0 for 2 cycles with in_valid=1 and a=0x1234 -> out_valid=0, sum=0x0000, cout=0, ovf=0, in_ready=1 after release; no result ever appears for that beat.
- Carry chain: SAT=0, a=0xFFFF, b=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1, ovf=0, out_valid exactly 2 edges after accept. Then a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Subtract:
  - a=0x0005, b=0x0007, sub=1, cin=1 (cin ignored) -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 -> SAT=0: sum=0x7FFF, cout=1, ovf=1. SAT=1: sum=0x8000, cout=1, ovf=1.
- Saturation: SAT=1, a=0x7FFF, b=0x0001, sub=0 -> sum=0x7FFF, cout=0, ovf=1. Then a=0x0003, b=0x0004 -> sum=0x0007, ovf=0 (no sticky state).
- Backpressure: stream a=1,2,3,4 with b=0x0010 back-to-back; hold out_ready=0 for 3 cycles after the first out_valid.
  - in_ready must drop with 2 beats held; sum must hold 0x0011 throughout the stall.
  - After release, results 0x0011, 0x0012, 0x0013, 0x0014 arrive in order, one per cycle, with no gaps or duplicates.
- Random: 10k random a/b/sub/cin beats with random in_valid/out_ready, against a reference model {cout,sum} = a + bx + c0 and ovf from sign bits, for both SAT values -> zero mismatches and a beat count equal to the accepted count.
